// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the registered logic unit and its BIST sequencer.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_ANDN = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        BIST_IDLE  = 2'd0,
        BIST_RUN   = 2'd1,
        BIST_CHECK = 2'd2,
        BIST_DONE  = 2'd3
    } bist_state_e;

    localparam int BIST_VECTORS = 16;

    // Nibble per op (ANDN, XOR, OR, AND from MSB), bit selected by {a,b};
    // the whole constant is therefore indexed directly by the BIST vector index.
    localparam logic [15:0] GOLDEN_TT = {4'b0100, 4'b0110, 4'b1110, 4'b1000};

endpackage

// File: rtl/logic_unit_bist_seq.sv
// BIST sequencer: sweeps all op/lane combinations, checks the registered result
// one cycle behind the drive against the golden table, and reports pass/error count.
module logic_unit_bist_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             out_valid,
    input  logic [WIDTH-1:0] result,
    output logic             run,
    output logic             start_acc,
    output logic [3:0]       idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_cnt
);

    bist_state_e state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        chk_en_q, chk_en_d;
    logic [3:0]  chk_idx_q, chk_idx_d;
    logic [4:0]  err_q, err_d;
    logic        pass_q, pass_d;
    logic [4:0]  err_cnt_q, err_cnt_d;
    logic        mismatch;
    logic [4:0]  err_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BIST_IDLE;
            idx_q     <= '0;
            chk_en_q  <= 1'b0;
            chk_idx_q <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            chk_en_q  <= chk_en_d;
            chk_idx_q <= chk_idx_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        mismatch  = chk_en_q && (result != {WIDTH{GOLDEN_TT[chk_idx_q]}});
        err_acc   = err_q + {4'd0, mismatch};
        state_d   = state_q;
        idx_d     = idx_q;
        chk_en_d  = (state_q == BIST_RUN);
        chk_idx_d = idx_q;
        err_d     = err_acc;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        start_acc = 1'b0;
        done      = 1'b0;
        case (state_q)
            BIST_IDLE: begin
                // A start while a result is still pending is dropped, not queued.
                if (start && !out_valid) begin
                    start_acc = 1'b1;
                    state_d   = BIST_RUN;
                    idx_d     = '0;
                    err_d     = '0;
                    pass_d    = 1'b0;
                    err_cnt_d = '0;
                end
            end
            BIST_RUN: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'(BIST_VECTORS - 1)) begin
                    state_d = BIST_CHECK;
                end
            end
            BIST_CHECK: begin
                state_d   = BIST_DONE;
                err_cnt_d = err_acc;
                pass_d    = (err_acc == 5'd0);
            end
            default: begin
                done    = 1'b1;
                state_d = BIST_IDLE;
            end
        endcase
    end

    assign run     = (state_q == BIST_RUN);
    assign busy    = (state_q == BIST_RUN) || (state_q == BIST_CHECK);
    assign idx     = idx_q;
    assign pass    = pass_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: rtl/logic_unit_bist.sv
// Registered WIDTH-bit logic unit (AND/OR/XOR/ANDN) with valid/ready handshake
// and a built-in self-test that drives the same datapath and output register.
module logic_unit_bist
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    input  logic             bist_start,
    input  logic             bist_inject,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_pass,
    output logic [4:0]       bist_err_cnt
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             bist_run;
    logic             bist_start_acc;
    logic [3:0]       bist_idx;
    op_e              op_sel;
    logic [WIDTH-1:0] opa, opb, result;
    logic             accept;

    logic_unit_bist_seq #(.WIDTH(WIDTH)) u_seq (
        .clk       (clk),
        .rst       (rst),
        .start     (bist_start),
        .out_valid (out_valid_q),
        .result    (out_q),
        .run       (bist_run),
        .start_acc (bist_start_acc),
        .idx       (bist_idx),
        .busy      (bist_busy),
        .done      (bist_done),
        .pass      (bist_pass),
        .err_cnt   (bist_err_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        op_sel = op_e'(op);
        opa    = in_0;
        opb    = in_1;
        if (bist_run) begin
            op_sel = op_e'(bist_idx[3:2]);
            opa    = {WIDTH{bist_idx[1]}};
            opb    = {WIDTH{bist_idx[0]}};
        end
        result = '0;
        case (op_sel)
            OP_AND:  result = opa & opb;
            OP_OR:   result = opa | opb;
            OP_XOR:  result = opa ^ opb;
            default: result = opa & ~opb;
        endcase
        if (bist_run && bist_inject) begin
            result[0] = ~result[0];
        end
    end

    assign in_ready = !bist_busy && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (bist_run || accept) begin
            out_d = result;
        end
        // An operand arriving with an accepted start is discarded so the run owns the register.
        if (bist_start_acc || bist_busy) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_logic_unit_bist.sv
// Scoreboard bench: driver pushes expected results, monitor pops on each handshake.
module tb_logic_unit_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] op = 2'd0;
    logic [7:0] in_0 = 8'h00;
    logic [7:0] in_1 = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out;
    logic       bist_start = 1'b0;
    logic       bist_inject = 1'b0;
    logic       bist_busy;
    logic       bist_done;
    logic       bist_pass;
    logic [4:0] bist_err_cnt;

    typedef struct {
        logic [7:0] data;
        int         due;
        bit         chk_lat;
    } exp_t;

    exp_t       dq[$];
    logic [5:0] bq[$];
    int         n_total = 0;
    int         n_pass = 0;
    int         cyc = 0;

    logic_unit_bist #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .in_0         (in_0),
        .in_1         (in_1),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out          (out),
        .bist_start   (bist_start),
        .bist_inject  (bist_inject),
        .bist_busy    (bist_busy),
        .bist_done    (bist_done),
        .bist_pass    (bist_pass),
        .bist_err_cnt (bist_err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
            $display("check %s: got %0h ok", name, act);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every data handshake and every BIST completion pulse.
    initial begin
        exp_t e;
        logic [5:0] b;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (dq.size() == 0) begin
                    chk("unexpected_out", 32'(out), 32'hFFFF_FFFF);
                end else begin
                    e = dq.pop_front();
                    chk("out_data", 32'(out), 32'(e.data));
                    if (e.chk_lat) chk("out_latency", 32'(cyc), 32'(e.due));
                end
            end
            if (!rst && bist_done) begin
                if (bq.size() == 0) begin
                    chk("unexpected_bist_done", 32'(bist_done), 32'd0);
                end else begin
                    b = bq.pop_front();
                    chk("bist_pass", 32'(bist_pass), 32'(b[5]));
                    chk("bist_err_cnt", 32'(bist_err_cnt), 32'(b[4:0]));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the operand is accepted.
    task automatic send(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] e, input bit lat, output int waited);
        exp_t x;
        op = o; in_0 = a; in_1 = b; in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 50) begin
                chk("send_timeout", 32'(waited), 32'd0);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        x.data = e; x.due = cyc + 1; x.chk_lat = lat;
        dq.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_bist(input bit inj, input bit exp_pass, input logic [4:0] exp_err,
                            input logic [7:0] exp_out);
        int n;
        bq.push_back({exp_pass, exp_err});
        bist_inject = inj;
        bist_start = 1'b1;
        @(posedge clk);
        #1;
        bist_start = 1'b0;
        n = 0;
        @(negedge clk);
        chk("bist_in_ready_low", 32'(in_ready), 32'd0);
        while (bist_busy && n < 40) begin
            chk_quiet_valid();
            n++;
            @(negedge clk);
        end
        chk("bist_busy_cycles", 32'(n), 32'd17);
        chk("bist_done_pulse", 32'(bist_done), 32'd1);
        @(negedge clk);
        chk("bist_done_low", 32'(bist_done), 32'd0);
        chk("bist_out_after", 32'(out), 32'(exp_out));
        bist_inject = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int bad_valid = 0;
    task automatic chk_quiet_valid();
        if (out_valid) bad_valid++;
    endtask

    initial begin
        int w;
        int seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_busy", 32'(bist_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pass", 32'(bist_pass), 32'd0);
        chk("rst_err_cnt", 32'(bist_err_cnt), 32'd0);
        chk("rst_done", 32'(bist_done), 32'd0);
        @(posedge clk);
        #1;

        // AND corner cases, then all four ops back-to-back on C3/A5
        send(2'd0, 8'h00, 8'h00, 8'h00, 1, w);
        send(2'd0, 8'h00, 8'hFF, 8'h00, 1, w);
        send(2'd0, 8'hFF, 8'hFF, 8'hFF, 1, w);
        send(2'd0, 8'hC3, 8'hA5, 8'h81, 1, w);
        send(2'd1, 8'hC3, 8'hA5, 8'hE7, 1, w);
        send(2'd2, 8'hC3, 8'hA5, 8'h66, 1, w);
        send(2'd3, 8'hC3, 8'hA5, 8'h42, 1, w);
        idle(2);

        // Backpressure: pending result must hold while a new operand waits
        out_ready = 1'b0;
        send(2'd0, 8'hF0, 8'h3C, 8'h30, 0, w);
        op = 2'd1; in_0 = 8'h0F; in_1 = 8'h30; in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_stable", 32'(out), 32'h30);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'd1, 8'h0F, 8'h30, 8'h3F, 1, w);
        chk("bp_same_cycle_accept", 32'(w), 32'd0);
        idle(2);

        // Start while a result is pending is ignored
        out_ready = 1'b0;
        send(2'd0, 8'hFF, 8'h0F, 8'h0F, 0, w);
        in_valid = 1'b0;
        bist_start = 1'b1;
        @(posedge clk);
        #1;
        bist_start = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bist_busy) seen++;
        end
        chk("start_ignored", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(3);

        run_bist(1'b0, 1'b1, 5'd0, 8'h00);
        chk("bist_out_valid_quiet", 32'(bad_valid), 32'd0);
        run_bist(1'b1, 1'b0, 5'd16, 8'h01);
        idle(2);

        // Reset in the middle of a run (idx 8), then a fresh clean run
        bist_start = 1'b1;
        @(posedge clk);
        #1;
        bist_start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_before", 32'(bist_busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bist_busy), 32'd0);
        chk("abort_out", 32'(out), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_err_cnt", 32'(bist_err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bist_done || bist_busy) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        run_bist(1'b0, 1'b1, 5'd0, 8'h00);

        // Final operand after BIST, then drain
        send(2'd2, 8'h5A, 8'hFF, 8'hA5, 1, w);
        idle(5);
        chk("data_queue_empty", 32'(dq.size()), 32'd0);
        chk("bist_queue_empty", 32'(bq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
